// File: rtl/frame_buffer_reader.sv
// Read-side controller for the ping-pong sample banks: streams a completed bank
// out as valid/ready samples with first/last tags, tracking pending frames and overruns.
module frame_buffer_reader #(
   parameter int unsigned ADDR_W    = 11,
   parameter int unsigned DATA_W    = 12,
   parameter int unsigned FRAME_LEN = 2048
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_ready,
   input  logic              frame_bank,
   input  logic [1:0]        wr_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [1:0]        rd_en,
   input  logic [DATA_W-1:0] rd_data0,
   input  logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_first,
   output logic              out_last,
   output logic              frame_done,
   output logic              overrun,
   output logic              collision,
   output logic              busy
);

   localparam int unsigned CW = ADDR_W + 1;
   localparam int unsigned EW = DATA_W + 2;
   localparam logic [CW-1:0] LAST_ADDR = CW'(FRAME_LEN - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t            state_q, state_d;
   logic              bank_q, bank_d;
   logic [CW-1:0]     iss_q, iss_d;
   logic              pend_vld_q, pend_vld_d;
   logic              pend_bank_q, pend_bank_d;
   logic              infl_q;
   logic [ADDR_W-1:0] infl_addr_q;
   logic [EW-1:0]     mem_q [2];
   logic              wptr_q, rptr_q;
   logic [1:0]        cnt_q;

   logic              pop_c, issue_c, done_c;
   logic [2:0]        occ_c;
   logic [EW-1:0]     push_entry_c;
   logic [DATA_W-1:0] rdata_c;

   // Occupancy after this cycle's pop, counting the read still in flight.
   assign pop_c   = (cnt_q != 2'd0) && out_ready;
   assign occ_c   = 3'(cnt_q) + 3'(infl_q) - 3'(pop_c);
   assign issue_c = (state_q == READ) && (occ_c < 3'd2);
   assign done_c  = pop_c && out_last;
   assign rdata_c = bank_q ? rd_data1 : rd_data0;
   assign push_entry_c = {({1'b0, infl_addr_q} == LAST_ADDR),
                          (infl_addr_q == '0), rdata_c};

   always_comb begin
      rd_en      = 2'b00;
      rd_addr    = '0;
      if (issue_c) begin
         rd_en   = bank_q ? 2'b10 : 2'b01;
         rd_addr = iss_q[ADDR_W-1:0];
      end
      collision  = |(rd_en & wr_en);
      out_valid  = (cnt_q != 2'd0);
      {out_last, out_first, out_data} = mem_q[rptr_q];
      frame_done = done_c;
      busy       = (state_q != IDLE);
   end

   always_comb begin
      state_d     = state_q;
      bank_d      = bank_q;
      iss_d       = iss_q;
      pend_vld_d  = pend_vld_q;
      pend_bank_d = pend_bank_q;
      overrun     = 1'b0;
      // A request while busy fills the single pending slot; a second one replaces it.
      if (frame_ready && (state_q != IDLE)) begin
         overrun     = pend_vld_q;
         pend_vld_d  = 1'b1;
         pend_bank_d = frame_bank;
      end
      if (issue_c) iss_d = iss_q + CW'(1);
      case (state_q)
         IDLE: begin
            if (pend_vld_q) begin
               state_d    = READ;
               bank_d     = pend_bank_q;
               iss_d      = '0;
               pend_vld_d = 1'b0;
            end else if (frame_ready) begin
               state_d = READ;
               bank_d  = frame_bank;
               iss_d   = '0;
            end
         end
         READ: begin
            if (issue_c && (iss_q == LAST_ADDR)) state_d = DRAIN;
         end
         DRAIN: begin
            if (done_c) begin
               if (pend_vld_d) begin
                  state_d    = READ;
                  bank_d     = pend_bank_d;
                  iss_d      = '0;
                  pend_vld_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bank_q      <= 1'b0;
         iss_q       <= '0;
         pend_vld_q  <= 1'b0;
         pend_bank_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bank_q      <= bank_d;
         iss_q       <= iss_d;
         pend_vld_q  <= pend_vld_d;
         pend_bank_q <= pend_bank_d;
      end
   end

   // Two-entry output FIFO fed by the 1-cycle BRAM return path.
   always_ff @(posedge clk) begin
      if (rst) begin
         infl_q      <= 1'b0;
         infl_addr_q <= '0;
         wptr_q      <= 1'b0;
         rptr_q      <= 1'b0;
         cnt_q       <= 2'd0;
         mem_q[0]    <= '0;
         mem_q[1]    <= '0;
      end else begin
         infl_q      <= issue_c;
         infl_addr_q <= iss_q[ADDR_W-1:0];
         if (infl_q) begin
            mem_q[wptr_q] <= push_entry_c;
            wptr_q        <= ~wptr_q;
         end
         if (pop_c) rptr_q <= ~rptr_q;
         cnt_q <= cnt_q + 2'(infl_q) - 2'(pop_c);
      end
   end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Scoreboard bench for frame_buffer_reader with FRAME_LEN = 2**ADDR_W = 8.
module tb_frame_buffer_reader;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 12;
   localparam int unsigned FLEN   = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              frame_ready = 1'b0;
   logic              frame_bank = 1'b0;
   logic [1:0]        wr_en = 2'b00;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0]        rd_en;
   logic [DATA_W-1:0] rd_data0, rd_data1;
   logic [DATA_W-1:0] out_data;
   logic              out_valid, out_ready, out_first, out_last;
   logic              frame_done, overrun, collision, busy;

   frame_buffer_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_LEN(FLEN)) dut (
      .clk(clk), .rst(rst), .frame_ready(frame_ready), .frame_bank(frame_bank),
      .wr_en(wr_en), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data0(rd_data0),
      .rd_data1(rd_data1), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
      .frame_done(frame_done), .overrun(overrun), .collision(collision), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              first;
      logic              last;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0, n_bad = 0;
   int   cyc = 0;
   int   acc_n = 0, iss0_n = 0, iss1_n = 0, coll_n = 0, ovr_n = 0, done_n = 0;
   int   first_cyc = 0, last_cyc = 0, done_cyc = 0, rise1_cyc = 0;
   logic prev_rd1 = 1'b0, prev_stall = 1'b0;
   logic [DATA_W+2:0] prev_beat = '0;
   logic [DATA_W-1:0] mem0 [FLEN];
   logic [DATA_W-1:0] mem1 [FLEN];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Bank memories with 1-cycle read latency.
   always @(posedge clk) begin
      if (rd_en[0]) rd_data0 <= mem0[rd_addr];
      if (rd_en[1]) rd_data1 <= mem1[rd_addr];
   end

   // Output monitor: pops the scoreboard on every accepted beat.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_stall = 1'b0;
         prev_rd1   = 1'b0;
      end else begin
         check("rd_en_onehot", 32'(rd_en != 2'b11), 32'd1);
         if (rd_en[0]) iss0_n++;
         if (rd_en[1]) iss1_n++;
         if (rd_en[1] && !prev_rd1) rise1_cyc = cyc;
         prev_rd1 = rd_en[1];
         if (collision) coll_n++;
         if (overrun) ovr_n++;
         if (frame_done) begin done_n++; done_cyc = cyc; end
         if (prev_stall) check("hold", 32'({out_valid, out_first, out_last, out_data}), 32'(prev_beat));
         if (out_valid && out_ready) begin
            acc_n++;
            if (sb.size() == 0) begin
               check("sb_underflow", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("data", 32'(out_data), 32'(e.data));
               check("first", 32'(out_first), 32'(e.first));
               check("last", 32'(out_last), 32'(e.last));
               check("done_w_last", 32'(frame_done), 32'(e.last));
               if (out_first) first_cyc = cyc;
               if (out_last) last_cyc = cyc;
            end
         end else begin
            check("done_no_accept", 32'(frame_done), 32'd0);
         end
         prev_stall = out_valid && !out_ready;
         prev_beat  = {out_valid, out_first, out_last, out_data};
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_frame(input logic bank);
      for (int i = 0; i < int'(FLEN); i++)
         sb.push_back('{data: (bank ? 12'h200 : 12'h100) + 12'(i),
                        first: (i == 0), last: (i == int'(FLEN) - 1)});
   endtask

   task automatic pulse_frame(input logic bank);
      frame_ready = 1'b1;
      frame_bank  = bank;
      tick(1);
      frame_ready = 1'b0;
   endtask

   task automatic pulse_chk(input logic bank, input logic exp_ovr);
      frame_ready = 1'b1;
      frame_bank  = bank;
      @(negedge clk);
      check("ovr_pulse", 32'(overrun), 32'(exp_ovr));
      tick(1);
      frame_ready = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy || sb.size() != 0) && n < 200) begin tick(1); n++; end
      if (n >= 200) check(tag, 32'd0, 32'd1);
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_n < target && n < 200) begin tick(1); n++; end
      if (n >= 200) check("wait_done_timeout", 32'(done_n), 32'(target));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
      check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_flags"}, 32'({out_first, out_last, frame_done, overrun, collision}), 32'd0);
   endtask

   initial begin
      int t0, a0, i0, i1, c0, o0, d0, n, drops, maxdiff, dfirst;
      logic [3:0] pat;
      for (int i = 0; i < int'(FLEN); i++) begin
         mem0[i] = 12'h100 + 12'(i);
         mem1[i] = 12'h200 + 12'(i);
      end
      out_ready = 1'b1;
      tick(3);
      rst = 1'b0;
      check_reset_outputs("reset");

      // Basic frame, full throughput.
      i0 = iss0_n; i1 = iss1_n;
      expect_frame(1'b0);
      t0 = cyc;
      pulse_frame(1'b0);
      wait_idle("basic_timeout");
      check("basic_first_lat", 32'(first_cyc - t0), 32'd3);
      check("basic_last_lat", 32'(last_cyc - t0), 32'd10);
      check("basic_iss0", 32'(iss0_n - i0), 32'(FLEN));
      check("basic_iss1", 32'(iss1_n - i1), 32'd0);

      // Backpressure with ready pattern 1,0,0,1.
      pat = 4'b1001;
      a0 = acc_n; i1 = iss1_n; maxdiff = 0; n = 0;
      expect_frame(1'b1);
      pulse_frame(1'b1);
      while ((busy || sb.size() != 0) && n < 200) begin
         out_ready = pat[n % 4];
         tick(1);
         n++;
         if ((iss1_n - i1) - (acc_n - a0) > maxdiff) maxdiff = (iss1_n - i1) - (acc_n - a0);
      end
      if (n >= 200) check("bp_timeout", 32'd0, 32'd1);
      out_ready = 1'b1;
      check("bp_accepted", 32'(acc_n - a0), 32'(FLEN));
      check("bp_issue_ahead", 32'(maxdiff <= 2), 32'd1);

      // Back-to-back frames.
      o0 = ovr_n; d0 = done_n; drops = 0; n = 0;
      expect_frame(1'b0);
      expect_frame(1'b1);
      pulse_frame(1'b0);
      tick(2);
      pulse_frame(1'b1);
      dfirst = -1;
      while (n < 200) begin
         if (done_n - d0 >= 1 && dfirst < 0) dfirst = done_cyc;
         if (done_n - d0 >= 2) break;
         if (!busy) drops++;
         tick(1);
         n++;
      end
      if (n >= 200) check("b2b_timeout", 32'd0, 32'd1);
      check("b2b_busy_drops", 32'(drops), 32'd0);
      check("b2b_restart", 32'(rise1_cyc - dfirst), 32'd1);
      check("b2b_no_overrun", 32'(ovr_n - o0), 32'd0);
      wait_idle("b2b_idle_timeout");

      // Overrun: pending bank0 replaced by bank1 while a bank1 frame runs.
      o0 = ovr_n; d0 = done_n;
      expect_frame(1'b0);
      pulse_frame(1'b0);
      tick(2);
      expect_frame(1'b1);
      pulse_chk(1'b1, 1'b0);
      wait_done(d0 + 1);
      tick(2);
      pulse_chk(1'b0, 1'b0);
      tick(1);
      pulse_chk(1'b1, 1'b1);
      expect_frame(1'b1);
      wait_idle("ovr_timeout");
      check("ovr_count", 32'(ovr_n - o0), 32'd1);

      // Collision on three issue cycles.
      c0 = coll_n;
      expect_frame(1'b0);
      pulse_frame(1'b0);
      wr_en = 2'b01;
      tick(3);
      wr_en = 2'b00;
      wait_idle("coll_timeout");
      check("coll_count", 32'(coll_n - c0), 32'd3);

      // Reset after the fourth accepted sample.
      a0 = acc_n; n = 0;
      expect_frame(1'b0);
      pulse_frame(1'b0);
      while (acc_n - a0 < 4 && n < 100) begin tick(1); n++; end
      if (n >= 100) check("rst_wait_timeout", 32'd0, 32'd1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      sb.delete();
      check_reset_outputs("midrst");
      tick(2);
      expect_frame(1'b0);
      t0 = cyc;
      pulse_frame(1'b0);
      wait_idle("rst_frame_timeout");
      check("rst_first_lat", 32'(first_cyc - t0), 32'd3);
      check("rst_last_lat", 32'(last_cyc - t0), 32'd10);

      tick(2);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/frame_buffer_reader.md
Name: frame_buffer_reader

Overview:
Read-side controller for the ping-pong sample buffers (two BRAMs of FRAME_LEN 12-bit samples) that the sampler/buffer writer fills. When the writer reports a completed frame, this block reads that bank on port B from address 0 to FRAME_LEN-1. It absorbs the BRAM read latency and delivers the samples as a valid/ready stream to downstream analysis blocks, with first/last markers. It also flags frame overruns and read/write bank collisions.

Parameters:
ADDR_W, 11, BRAM address width
DATA_W, 12, sample width
FRAME_LEN, 2048, samples per frame; must be <= 2**ADDR_W

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous reset, active-high
frame_ready  in  1  one-cycle pulse from writer: a bank has just been filled
frame_bank  in  1  bank index completed, valid with frame_ready
wr_en  in  2  writer port-A write enables per bank (collision check)
rd_addr  out  ADDR_W  port-B address, shared by both banks
rd_en  out  2  port-B enable per bank; only the active bank bit may be 1
rd_data0  in  DATA_W  bank 0 port-B data, 1 cycle after rd_en[0]
rd_data1  in  DATA_W  bank 1 port-B data, 1 cycle after rd_en[1]
out_data  out  DATA_W  sample stream
out_valid  out  1  out_data valid
out_ready  in  1  downstream accept
out_first  out  1  qualifies sample at address 0
out_last  out  1  qualifies sample at address FRAME_LEN-1
frame_done  out  1  one-cycle pulse when the last sample is accepted
overrun  out  1  one-cycle pulse when a frame is dropped or replaced
collision  out  1  one-cycle pulse when a read is issued to a bank whose wr_en bit is high
busy  out  1  high from frame start until frame_done

Behaviour:
- Reset: state IDLE. rd_addr=0, rd_en=0, out_valid=0, out_first=0, out_last=0, frame_done=0, overrun=0, collision=0, busy=0. Output FIFO and pending slot are cleared. Reset mid-frame discards everything; any in-flight read data is ignored.
- States: IDLE, READ, DRAIN.
- IDLE:
  - On frame_ready, latch frame_bank as the active bank, set issue address to 0, go to READ. busy rises next cycle.
  - If a pending frame exists, start it the same way, with priority over nothing.
- READ, issue rule:
  - A read is issued when (fifo_count + inflight) < 2. The output FIFO is 2 deep and the read latency is fixed at 1.
  - On a read: rd_en[active]=1, rd_addr=issue address, issue address increments.
  - After the read of FRAME_LEN-1 is issued, go to DRAIN.
- Returned data: one cycle after a read, the active bank's rd_data is pushed into the FIFO with tags first=(addr==0) and last=(addr==FRAME_LEN-1).
- Full throughput: with out_ready held 1, one sample per cycle. First out_valid appears 2 cycles after the READ entry cycle. No bubbles after that.
- Backpressure:
  - out_data, out_first and out_last are held stable while out_valid && !out_ready.
  - Samples are never dropped or duplicated.
- DRAIN: when the last-tagged sample is accepted (out_valid && out_ready && out_last):
  - pulse frame_done;
  - go to IDLE, or straight to READ if a frame is pending (pending cleared, no idle cycle);
  - busy stays high across a back-to-back start.
- frame_ready while busy:
  - If there is no pending frame, store frame_bank as pending; no overrun.
  - If a pending frame already exists, replace it with the new bank and pulse overrun.
  - frame_ready on the same cycle as frame_done counts as arriving while busy.
- frame_ready in IDLE on the cycle a pending frame would start cannot occur, because the pending frame starts immediately.
- Collision: pulses on every cycle a read is issued while wr_en[active]=1. Reading continues unchanged.
- Widths: the issue address counter is ADDR_W+1 bits wide to detect the end of frame without wrap. When FRAME_LEN = 2**ADDR_W, rd_addr still covers 0..FRAME_LEN-1.

Test Plan:
- Basic frame, out_ready=1, FRAME_LEN=8, bank0 holds 0x100..0x107, frame_ready with frame_bank=0 at cycle T -> out_data 0x100..0x107 on cycles T+3..T+10; out_first only with 0x100; out_last and frame_done with 0x107; rd_en only ever 2'b01.
- Backpressure, bank1 holds 0x200..0x207, out_ready toggling 1,0,0,1 repeating -> exactly 8 accepted beats in order 0x200..0x207; data held stable during stalls; rd_en[1] issues never exceed accepted beats + 2.
- Back-to-back: second frame_ready (bank1) during a bank0 frame -> no overrun; bank1 READ starts the cycle after frame_done; busy never drops; 16 samples in order.
- Overrun: three frame_ready pulses (banks 1, 0, 1) during an active frame -> exactly one overrun pulse, on the third pulse; the next frame read is bank1.
- Collision: wr_en=2'b01 held while reading bank0 for 3 issue cycles -> 3 collision pulses; stream content unaffected.
- Reset mid-frame: rst for 1 cycle after the 4th accepted sample -> next cycle all outputs at reset values; a new frame_ready then produces a full 8-sample frame with out_first on the first sample.
